// File: rtl/noc.sv
// Radix-RADIX switch: one memory-side port fans out to RADIX core ports (M2C),
// and RADIX core ports merge onto the memory port through a round-robin arbiter (C2M).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef RADIX
`define RADIX 2
`endif

module noc #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_l,
    input  logic                                      FIFO_M2C_ENQ,
    input  logic [`ADDR_WIDTH+`DATA_WIDTH-1:0]         FIFO_M2C_IN,
    output logic                                      FIFO_M2C_FULL,
    output logic [`RADIX-1:0]                         FIFO_M2C_ENQ_downstream,
    output logic [`RADIX*(`ADDR_WIDTH+`DATA_WIDTH)-1:0] FIFO_M2C_OUT,
    input  logic [`RADIX-1:0]                         FIFO_M2C_FULL_downstream,
    input  logic [`RADIX-1:0]                         FIFO_C2M_ENQ,
    input  logic [`RADIX*(`ADDR_WIDTH+`DATA_WIDTH)-1:0] FIFO_C2M_IN,
    output logic [`RADIX-1:0]                         FIFO_C2M_FULL,
    output logic                                      FIFO_C2M_ENQ_downstream,
    output logic [`ADDR_WIDTH+`DATA_WIDTH-1:0]         FIFO_C2M_OUT,
    input  logic                                      FIFO_C2M_FULL_downstream
);
    localparam int RADIX = `RADIX;
    localparam int W     = `ADDR_WIDTH + `DATA_WIDTH;
    localparam int DW    = $clog2(RADIX);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    logic [W-1:0]         m2c_mem_q [FIFO_DEPTH];
    logic [W-1:0]         m2c_mem_d [FIFO_DEPTH];
    logic [PW-1:0]        m2c_rd_q, m2c_rd_d, m2c_wr_q, m2c_wr_d;
    logic [CW-1:0]        m2c_cnt_q, m2c_cnt_d;
    logic [RADIX-1:0]     m2c_enq_ds_q, m2c_enq_ds_d;
    logic [RADIX*W-1:0]   m2c_out_q, m2c_out_d;
    logic [W-1:0]         m2c_head;
    logic [DW-1:0]        m2c_dest;
    logic                 m2c_push, m2c_pop;

    logic [W-1:0]         c2m_mem_q [RADIX][FIFO_DEPTH];
    logic [W-1:0]         c2m_mem_d [RADIX][FIFO_DEPTH];
    logic [PW-1:0]        c2m_rd_q [RADIX];
    logic [PW-1:0]        c2m_rd_d [RADIX];
    logic [PW-1:0]        c2m_wr_q [RADIX];
    logic [PW-1:0]        c2m_wr_d [RADIX];
    logic [CW-1:0]        c2m_cnt_q [RADIX];
    logic [CW-1:0]        c2m_cnt_d [RADIX];
    logic [DW-1:0]        c2m_last_q, c2m_last_d;
    logic                 c2m_enq_ds_q, c2m_enq_ds_d;
    logic [W-1:0]         c2m_out_q, c2m_out_d;
    logic [RADIX-1:0]     c2m_push, c2m_pop;
    logic [DW-1:0]        c2m_scan, c2m_gnt;
    logic                 c2m_valid;

    assign m2c_head = m2c_mem_q[m2c_rd_q];
    assign m2c_dest = m2c_head[W-1 -: DW];

    always_comb begin
        m2c_mem_d    = m2c_mem_q;
        m2c_rd_d     = m2c_rd_q;
        m2c_wr_d     = m2c_wr_q;
        m2c_enq_ds_d = '0;
        m2c_out_d    = m2c_out_q;
        // FULL comes from the registered count, so a same-cycle pop never frees a slot for the push.
        m2c_push     = FIFO_M2C_ENQ && (m2c_cnt_q != DEPTH_C);
        m2c_pop      = (m2c_cnt_q != '0) && !FIFO_M2C_FULL_downstream[m2c_dest];
        if (m2c_push) begin
            m2c_mem_d[m2c_wr_q] = FIFO_M2C_IN;
            m2c_wr_d            = ptr_inc(m2c_wr_q);
        end
        if (m2c_pop) begin
            m2c_rd_d                    = ptr_inc(m2c_rd_q);
            m2c_enq_ds_d[m2c_dest]      = 1'b1;
            m2c_out_d[m2c_dest*W +: W]  = m2c_head;
        end
        m2c_cnt_d = m2c_cnt_q + CW'(m2c_push) - CW'(m2c_pop);
    end

    always_comb begin
        c2m_mem_d    = c2m_mem_q;
        c2m_rd_d     = c2m_rd_q;
        c2m_wr_d     = c2m_wr_q;
        c2m_cnt_d    = c2m_cnt_q;
        c2m_last_d   = c2m_last_q;
        c2m_enq_ds_d = 1'b0;
        c2m_out_d    = c2m_out_q;
        c2m_push     = '0;
        c2m_pop      = '0;
        c2m_scan     = '0;
        c2m_gnt      = '0;
        c2m_valid    = 1'b0;
        for (int i = 0; i < RADIX; i++) begin
            c2m_push[i] = FIFO_C2M_ENQ[i] && (c2m_cnt_q[i] != DEPTH_C);
            if (c2m_push[i]) begin
                c2m_mem_d[i][c2m_wr_q[i]] = FIFO_C2M_IN[i*W +: W];
                c2m_wr_d[i]               = ptr_inc(c2m_wr_q[i]);
            end
        end
        // Search starts just after the last winner; RADIX is a power of two so the index wraps naturally.
        for (int k = 0; k < RADIX; k++) begin
            c2m_scan = c2m_last_q + DW'(k + 1);
            if (!c2m_valid && (c2m_cnt_q[c2m_scan] != '0)) begin
                c2m_valid = 1'b1;
                c2m_gnt   = c2m_scan;
            end
        end
        if (c2m_valid && !FIFO_C2M_FULL_downstream) begin
            c2m_pop[c2m_gnt]   = 1'b1;
            c2m_rd_d[c2m_gnt]  = ptr_inc(c2m_rd_q[c2m_gnt]);
            c2m_enq_ds_d       = 1'b1;
            c2m_out_d          = c2m_mem_q[c2m_gnt][c2m_rd_q[c2m_gnt]];
            c2m_last_d         = c2m_gnt;
        end
        for (int i = 0; i < RADIX; i++) begin
            c2m_cnt_d[i] = c2m_cnt_q[i] + CW'(c2m_push[i]) - CW'(c2m_pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            m2c_mem_q    <= '{default: '0};
            m2c_rd_q     <= '0;
            m2c_wr_q     <= '0;
            m2c_cnt_q    <= '0;
            m2c_enq_ds_q <= '0;
            m2c_out_q    <= '0;
            c2m_mem_q    <= '{default: '0};
            c2m_rd_q     <= '{default: '0};
            c2m_wr_q     <= '{default: '0};
            c2m_cnt_q    <= '{default: '0};
            c2m_last_q   <= DW'(RADIX - 1);
            c2m_enq_ds_q <= 1'b0;
            c2m_out_q    <= '0;
        end else begin
            m2c_mem_q    <= m2c_mem_d;
            m2c_rd_q     <= m2c_rd_d;
            m2c_wr_q     <= m2c_wr_d;
            m2c_cnt_q    <= m2c_cnt_d;
            m2c_enq_ds_q <= m2c_enq_ds_d;
            m2c_out_q    <= m2c_out_d;
            c2m_mem_q    <= c2m_mem_d;
            c2m_rd_q     <= c2m_rd_d;
            c2m_wr_q     <= c2m_wr_d;
            c2m_cnt_q    <= c2m_cnt_d;
            c2m_last_q   <= c2m_last_d;
            c2m_enq_ds_q <= c2m_enq_ds_d;
            c2m_out_q    <= c2m_out_d;
        end
    end

    always_comb begin
        FIFO_C2M_FULL = '0;
        for (int i = 0; i < RADIX; i++) begin
            FIFO_C2M_FULL[i] = (c2m_cnt_q[i] == DEPTH_C);
        end
    end

    assign FIFO_M2C_FULL           = (m2c_cnt_q == DEPTH_C);
    assign FIFO_M2C_ENQ_downstream = m2c_enq_ds_q;
    assign FIFO_M2C_OUT            = m2c_out_q;
    assign FIFO_C2M_ENQ_downstream = c2m_enq_ds_q;
    assign FIFO_C2M_OUT            = c2m_out_q;

endmodule

// File: tb/tb_noc.sv
// Directed bench for noc (RADIX=2): scoreboard queues filled at stimulus time,
// drained by negedge monitors that also flag any delivery into a full consumer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef RADIX
`define RADIX 2
`endif

module tb_noc;
    localparam int RADIX = `RADIX;
    localparam int W     = `ADDR_WIDTH + `DATA_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_l;
    logic                 m2c_enq;
    logic [W-1:0]         m2c_in;
    logic                 m2c_full;
    logic [RADIX-1:0]     m2c_enq_ds;
    logic [RADIX*W-1:0]   m2c_out;
    logic [RADIX-1:0]     m2c_full_ds;
    logic [RADIX-1:0]     c2m_enq;
    logic [RADIX*W-1:0]   c2m_in;
    logic [RADIX-1:0]     c2m_full;
    logic                 c2m_enq_ds;
    logic [W-1:0]         c2m_out;
    logic                 c2m_full_ds;

    int checks = 0;
    int errors = 0;

    int           m2c_exp_port [$];
    logic [W-1:0] m2c_exp_data [$];
    logic [W-1:0] c2m_exp [$];

    logic [RADIX-1:0] m2c_prev_full = '0;
    logic             c2m_prev_full = 1'b0;
    logic [RADIX-1:0] mon_oh;
    int               mon_port;
    logic [W-1:0]     mon_data;

    noc dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .FIFO_M2C_ENQ             (m2c_enq),
        .FIFO_M2C_IN              (m2c_in),
        .FIFO_M2C_FULL            (m2c_full),
        .FIFO_M2C_ENQ_downstream  (m2c_enq_ds),
        .FIFO_M2C_OUT             (m2c_out),
        .FIFO_M2C_FULL_downstream (m2c_full_ds),
        .FIFO_C2M_ENQ             (c2m_enq),
        .FIFO_C2M_IN              (c2m_in),
        .FIFO_C2M_FULL            (c2m_full),
        .FIFO_C2M_ENQ_downstream  (c2m_enq_ds),
        .FIFO_C2M_OUT             (c2m_out),
        .FIFO_C2M_FULL_downstream (c2m_full_ds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Destination is the address MSB when RADIX=2.
    function automatic logic [W-1:0] pkt(input logic dest, input logic [W-2:0] body);
        return {dest, body};
    endfunction

    always @(posedge clk) begin
        m2c_prev_full <= m2c_full_ds;
        c2m_prev_full <= c2m_full_ds;
    end

    always @(negedge clk) begin
        if (|m2c_enq_ds) begin
            chk("m2c_enq_into_full", 64'(m2c_enq_ds & m2c_prev_full), 64'd0);
            chk("m2c_unexpected", 64'(m2c_exp_port.size() != 0), 64'd1);
            if (m2c_exp_port.size() != 0) begin
                mon_port = m2c_exp_port.pop_front();
                mon_data = m2c_exp_data.pop_front();
                mon_oh = '0;
                mon_oh[mon_port] = 1'b1;
                chk("m2c_enq_port", 64'(m2c_enq_ds), 64'(mon_oh));
                chk("m2c_out_data", 64'(m2c_out[mon_port*W +: W]), 64'(mon_data));
            end
        end
        if (c2m_enq_ds === 1'b1) begin
            chk("c2m_enq_into_full", 64'(c2m_prev_full), 64'd0);
            chk("c2m_unexpected", 64'(c2m_exp.size() != 0), 64'd1);
            if (c2m_exp.size() != 0) begin
                chk("c2m_out_data", 64'(c2m_out), 64'(c2m_exp.pop_front()));
            end
        end
    end

    initial begin
        rst_l = 1'b1;
        m2c_enq = 1'b0; m2c_in = '0; m2c_full_ds = '0;
        c2m_enq = '0;   c2m_in = '0; c2m_full_ds = 1'b0;

        // Reset state
        tick(2);
        chk("rst_m2c_full", 64'(m2c_full), 64'd0);
        chk("rst_c2m_full", 64'(c2m_full), 64'd0);
        chk("rst_m2c_enq", 64'(m2c_enq_ds), 64'd0);
        chk("rst_c2m_enq", 64'(c2m_enq_ds), 64'd0);
        chk("rst_m2c_out", 64'(m2c_out), 64'd0);
        chk("rst_c2m_out", 64'(c2m_out), 64'd0);
        rst_l = 1'b0;
        tick();

        // M2C routing, back-to-back packets to different ports
        m2c_full_ds = 2'b00;
        m2c_enq = 1'b1; m2c_in = pkt(1'b0, '1);
        m2c_exp_port.push_back(0); m2c_exp_data.push_back(pkt(1'b0, '1));
        tick();
        m2c_in = pkt(1'b1, '0);
        m2c_exp_port.push_back(1); m2c_exp_data.push_back(pkt(1'b1, '0));
        tick();
        m2c_enq = 1'b0;
        @(negedge clk);
        chk("m2c_route_first_enq", 64'(m2c_enq_ds), 64'b01);
        chk("m2c_route_first_out", 64'(m2c_out[W-1:0]), 64'(pkt(1'b0, '1)));
        @(negedge clk);
        chk("m2c_route_second_enq", 64'(m2c_enq_ds), 64'b10);
        chk("m2c_route_second_out", 64'(m2c_out[2*W-1:W]), 64'(pkt(1'b1, '0)));
        chk("m2c_out0_hold", 64'(m2c_out[W-1:0]), 64'(pkt(1'b0, '1)));
        tick(2);

        // M2C backpressure: 4 accepted, 5th dropped
        m2c_full_ds = 2'b11;
        for (int i = 0; i < 5; i++) begin
            m2c_enq = 1'b1;
            m2c_in = pkt(1'(i % 2), (W-1)'(32'hA00 + i));
            if (i < 4) begin
                m2c_exp_port.push_back(i % 2);
                m2c_exp_data.push_back(pkt(1'(i % 2), (W-1)'(32'hA00 + i)));
            end
            tick();
            if (i == 2) chk("m2c_full_at_3", 64'(m2c_full), 64'd0);
            if (i == 3) chk("m2c_full_at_4", 64'(m2c_full), 64'd1);
        end
        m2c_enq = 1'b0;
        tick(3);
        chk("m2c_bp_no_enq", 64'(m2c_enq_ds), 64'd0);
        chk("m2c_bp_pending", 64'(m2c_exp_port.size()), 64'd4);
        m2c_full_ds = 2'b00;
        tick();
        chk("m2c_full_clears", 64'(m2c_full), 64'd0);
        tick(6);
        chk("m2c_bp_drained", 64'(m2c_exp_port.size()), 64'd0);

        // M2C head-of-line blocking
        m2c_full_ds = 2'b01;
        m2c_enq = 1'b1; m2c_in = pkt(1'b0, 'h1234);
        m2c_exp_port.push_back(0); m2c_exp_data.push_back(pkt(1'b0, 'h1234));
        tick();
        m2c_in = pkt(1'b1, 'h1ABC);
        m2c_exp_port.push_back(1); m2c_exp_data.push_back(pkt(1'b1, 'h1ABC));
        tick();
        m2c_enq = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("m2c_hol_blocked", 64'(m2c_enq_ds), 64'd0);
        end
        tick();
        m2c_full_ds = 2'b00;
        tick(5);

        // C2M round-robin, simultaneous push from both cores
        c2m_full_ds = 1'b0;
        c2m_enq = 2'b11;
        c2m_in = {pkt(1'b1, '0), pkt(1'b0, '1)};
        c2m_exp.push_back(pkt(1'b0, '1));
        c2m_exp.push_back(pkt(1'b1, '0));
        tick();
        c2m_enq = 2'b00;
        tick();
        @(negedge clk);
        chk("c2m_rr_first_enq", 64'(c2m_enq_ds), 64'd1);
        chk("c2m_rr_first_out", 64'(c2m_out), 64'(pkt(1'b0, '1)));
        @(negedge clk);
        chk("c2m_rr_second_enq", 64'(c2m_enq_ds), 64'd1);
        chk("c2m_rr_second_out", 64'(c2m_out), 64'(pkt(1'b1, '0)));
        @(negedge clk);
        chk("c2m_rr_idle", 64'(c2m_enq_ds), 64'd0);
        tick();

        // Core0 pushes every cycle; core1's single packet must win the second slot
        for (int i = 0; i < 6; i++) begin
            c2m_enq = (i == 0) ? 2'b11 : 2'b01;
            c2m_in = {pkt(1'b1, 'h200), pkt(1'b0, (W-1)'(32'h100 + i))};
            c2m_exp.push_back(pkt(1'b0, (W-1)'(32'h100 + i)));
            if (i == 0) c2m_exp.push_back(pkt(1'b1, 'h200));
            tick();
        end
        c2m_enq = 2'b00;
        tick(10);
        chk("c2m_starve_drained", 64'(c2m_exp.size()), 64'd0);

        // C2M backpressure; last winner was core0, so core1 leads the drain
        c2m_full_ds = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c2m_enq = 2'b11;
            c2m_in = {pkt(1'b1, (W-1)'(32'h400 + i)), pkt(1'b0, (W-1)'(32'h300 + i))};
            if (i < 4) begin
                c2m_exp.push_back(pkt(1'b1, (W-1)'(32'h400 + i)));
                c2m_exp.push_back(pkt(1'b0, (W-1)'(32'h300 + i)));
            end
            tick();
            if (i == 2) chk("c2m_full_at_3", 64'(c2m_full), 64'b00);
            if (i == 3) chk("c2m_full_at_4", 64'(c2m_full), 64'b11);
        end
        c2m_enq = 2'b00;
        tick(3);
        chk("c2m_bp_no_enq", 64'(c2m_enq_ds), 64'd0);
        c2m_full_ds = 1'b0;
        tick();
        chk("c2m_full_after_pop", 64'(c2m_full), 64'b01);
        tick(10);
        chk("c2m_bp_drained", 64'(c2m_exp.size()), 64'd0);

        // Reset mid-operation discards buffered packets and ignores ENQ
        m2c_full_ds = 2'b11;
        c2m_full_ds = 1'b1;
        m2c_enq = 1'b1; m2c_in = pkt(1'b0, 'h55);
        c2m_enq = 2'b01; c2m_in = {pkt(1'b1, 'h66), pkt(1'b0, 'h77)};
        tick(2);
        rst_l = 1'b1;
        tick(2);
        rst_l = 1'b0;
        m2c_enq = 1'b0;
        c2m_enq = 2'b00;
        chk("midrst_m2c_full", 64'(m2c_full), 64'd0);
        chk("midrst_c2m_full", 64'(c2m_full), 64'd0);
        m2c_full_ds = 2'b00;
        c2m_full_ds = 1'b0;
        tick(6);

        chk("end_m2c_queue_empty", 64'(m2c_exp_port.size()), 64'd0);
        chk("end_c2m_queue_empty", 64'(c2m_exp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
